// File: rtl/sr_driver.sv
// Pulse-shaping driver for a downstream SR latch: one s or r pulse per command, then a gap and done.
// Optional SR_VERIFY_EN adds the q_fb input and a sticky err flag from a feedback check.
module sr_driver #(
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
`ifdef SR_VERIFY_EN
    input  logic q_fb,
`endif
    output logic s,
    output logic r,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [2:0] {
        StIdle,
        StPulseS,
        StPulseR,
        StGap,
        StFin
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       last_pulse, last_gap;

    assign last_pulse = (cnt_q == 8'(PULSE_CYCLES - 1));
    assign last_gap   = (cnt_q == 8'(GAP_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            StIdle: begin
                // Clear has priority; a simultaneous set is dropped.
                if (clr_req) begin
                    state_d = StPulseR;
                end else if (set_req) begin
                    state_d = StPulseS;
                end
            end
            StPulseS, StPulseR: begin
                if (last_pulse) begin
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StGap: begin
                if (last_gap) begin
                    state_d = StFin;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            s       <= 1'b0;
            r       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s       <= (state_d == StPulseS);
            r       <= (state_d == StPulseR);
            busy    <= (state_d == StPulseS) || (state_d == StPulseR) || (state_d == StGap);
            done    <= (state_d == StFin);
        end
    end

`ifdef SR_VERIFY_EN
    logic exp_q_q, exp_q_d;
    logic err_d;
    logic mismatch;

    // Remember which level the latch should settle to for the end-of-gap check.
    always_comb begin
        exp_q_d = exp_q_q;
        if (state_q == StIdle && state_d == StPulseS) begin
            exp_q_d = 1'b1;
        end else if (state_q == StIdle && state_d == StPulseR) begin
            exp_q_d = 1'b0;
        end
    end

    assign mismatch = (state_q == StGap) && last_gap && (q_fb != exp_q_q);
    assign err_d    = err | mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q_q <= 1'b0;
            err     <= 1'b0;
        end else begin
            exp_q_q <= exp_q_d;
            err     <= err_d;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
